mdu_sequencer: RTL and testbench

Sequencer that sits between the execute stage and the iterative multiplier and 32-bit divider units of the RV32IM pipeline. It accepts one M-extension operation at a time and latches its operands. It issues a single start pulse to the correct unit, stalls the pipeline until the unit reports done, and presents the result for exactly one cycle. Division-by-zero and signed-overflow cases are resolved locally in one cycle without engaging the divider. Pipeline flush and a hung-unit watchdog are handled here.

---
 rtl/mdu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mdu_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Sequencer between execute and the iterative mul/div units: latches one M-op,
// pulses the unit start, stalls until done (or watchdog), then strobes the result.
module mdu_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [4:0]  alu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        mul_start,
  output logic        div_start,
  output logic [1:0]  mul_opcode,
  output logic [1:0]  div_opcode,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  input  logic        mul_done,
  input  logic        div_done,
  input  logic [31:0] mul_result,
  input  logic [31:0] div_result,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]    r_state;
  logic [31:0]   r_op1;
  logic [31:0]   r_op2;
  logic [1:0]    r_opcode;
  logic          r_is_div;
  logic [4:0]    r_rd;
  logic [31:0]   r_wb_data;
  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  logic [4:0]    w_op_idx;
  logic          w_is_m;
  logic          w_accept;
  logic          w_req_div;
  logic          w_ovf;
  logic          w_fast;
  logic [31:0]   w_fast_data;
  logic          w_done;
  logic [31:0]   w_result;
  logic [CW-1:0] w_cnt_inc;
  logic          w_tmo;

  // M-ops occupy codes 11..18: bit 2 of the offset picks the divider, bits 1:0 the unit opcode
  assign w_op_idx  = alu_op - 5'd11;
  assign w_is_m    = (alu_op >= 5'd11) && (alu_op <= 5'd18);
  assign w_accept  = (r_state == S_IDLE) && req_valid && w_is_m && !flush;
  assign w_req_div = w_op_idx[2];
  assign w_ovf     = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF) && !w_op_idx[0];
  assign w_fast    = w_req_div && ((src_b == 32'd0) || w_ovf);

  always_comb begin
    w_fast_data = 32'd0;
    if (src_b == 32'd0)
      w_fast_data = w_op_idx[1] ? src_a : 32'hFFFF_FFFF;
    else if (!w_op_idx[1])
      w_fast_data = 32'h8000_0000;
  end

  assign w_done    = r_is_div ? div_done : mul_done;
  assign w_result  = r_is_div ? div_result : mul_result;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_tmo     = (w_cnt_inc == TMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op1     <= 32'd0;
      r_op2     <= 32'd0;
      r_opcode  <= 2'd0;
      r_is_div  <= 1'b0;
      r_rd      <= 5'd0;
      r_wb_data <= 32'd0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op1    <= src_a;
            r_op2    <= src_b;
            r_opcode <= w_op_idx[1:0];
            r_is_div <= w_req_div;
            r_rd     <= rd_in;
            if (w_fast) begin
              r_wb_data <= w_fast_data;
              r_state   <= S_RESP;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (w_done) begin
            if (flush) begin
              r_state <= S_IDLE;
            end else begin
              r_wb_data <= w_result;
              r_state   <= S_RESP;
            end
          end else if (w_tmo) begin
            r_timeout <= 1'b1;
            if (flush) begin
              r_state <= S_IDLE;
            end else begin
              r_wb_data <= 32'd0;
              r_state   <= S_RESP;
            end
          end else begin
            r_cnt   <= w_cnt_inc;
            r_state <= flush ? S_DRAIN : S_WAIT;
          end
        end
        S_DRAIN: begin
          // the killed op's unit must still finish before a new op may start
          if (w_done) begin
            r_state <= S_IDLE;
          end else if (w_tmo) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall = w_accept || (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                 ((r_state == S_DRAIN) && req_valid && w_is_m);
  assign wb_valid    = (r_state == S_RESP) && !flush;
  assign wb_data     = r_wb_data;
  assign wb_rd       = r_rd;
  assign mul_start   = (r_state == S_ISSUE) && !r_is_div;
  assign div_start   = (r_state == S_ISSUE) && r_is_div;
  assign mul_opcode  = r_opcode;
  assign div_opcode  = r_opcode;
  assign operand1    = r_op1;
  assign operand2    = r_op2;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: unit path, fast paths, flush/drain,
// watchdog, stray done pulses and asynchronous reset.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [4:0]  alu_op;
  logic [31:0] src_a, src_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        stall, wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        mul_start, div_start;
  logic [1:0]  mul_opcode, div_opcode;
  logic [31:0] operand1, operand2;
  logic        mul_done, div_done;
  logic [31:0] mul_result, div_result;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int stall_cnt, mstart_cnt, dstart_cnt, wbv_cnt, start_c, wbv_c;
  logic [31:0] got_data;
  logic [4:0]  got_rd;

  localparam logic [4:0] OP_MUL = 5'b01011, OP_MULH = 5'b01100, OP_MULHU = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111, OP_DIVU = 5'b10000, OP_REM = 5'b10001;
  localparam logic [4:0] OP_REMU = 5'b10010;

  mdu_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .alu_op(alu_op),
    .src_a(src_a), .src_b(src_b), .rd_in(rd_in), .flush(flush),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .mul_start(mul_start), .div_start(div_start),
    .mul_opcode(mul_opcode), .div_opcode(div_opcode),
    .operand1(operand1), .operand2(operand2),
    .mul_done(mul_done), .div_done(div_done),
    .mul_result(mul_result), .div_result(div_result),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    stall_cnt = 0; mstart_cnt = 0; dstart_cnt = 0; wbv_cnt = 0;
    start_c = -1; wbv_c = -1; got_data = 32'hX; got_rd = 5'hX;
  endtask

  task automatic record(input int c);
    if (stall) stall_cnt++;
    if (mul_start) begin mstart_cnt++; start_c = c; end
    if (div_start) begin dstart_cnt++; start_c = c; end
    if (wb_valid) begin wbv_cnt++; wbv_c = c; got_data = wb_data; got_rd = wb_rd; end
  endtask

  // Fast-path op: accept now, result strobe next cycle, no unit start.
  task automatic fast_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int starts;
    starts = 0;
    req_valid = 1'b1; alu_op = op; src_a = a; src_b = b; rd_in = rd;
    smp();
    chk({tag, "_stall_accept"}, 32'(stall), 32'd1);
    chk({tag, "_wbv_accept"}, 32'(wb_valid), 32'd0);
    starts += int'(mul_start) + int'(div_start);
    nxt();
    smp();
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, "_stall_resp"}, 32'(stall), 32'd0);
    starts += int'(mul_start) + int'(div_start);
    chk({tag, "_no_start"}, 32'(starts), 32'd0);
    nxt();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; alu_op = 5'd0; src_a = 32'd0; src_b = 32'd0;
    rd_in = 5'd0; flush = 1'b0; mul_done = 1'b0; div_done = 1'b0;
    mul_result = 32'd0; div_result = 32'd0;
    nxt(); nxt();
    smp();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_op1", operand1, 32'd0);
    rst = 1'b0;
    nxt();

    // Non-M op is neither accepted nor stalled
    req_valid = 1'b1; alu_op = 5'b00001; src_a = 32'd1; src_b = 32'd2;
    smp();
    chk("nonm_stall", 32'(stall), 32'd0);
    nxt(); smp();
    chk("nonm_no_start", 32'(mul_start | div_start), 32'd0);
    req_valid = 1'b0;
    nxt();

    // MUL 7*6, done 33 cycles after start
    clr_stats();
    for (int c = 0; c < 38; c++) begin
      req_valid = (c <= 35); alu_op = OP_MUL; src_a = 32'd7; src_b = 32'd6; rd_in = 5'd5;
      mul_done = (c == 34); mul_result = (c == 34) ? 32'd42 : 32'hDEAD_BEEF;
      smp();
      record(c);
      if (c == 1) begin
        chk("mul_op1", operand1, 32'd7);
        chk("mul_op2", operand2, 32'd6);
        chk("mul_opc", 32'(mul_opcode), 32'd0);
      end
      nxt();
    end
    mul_done = 1'b0;
    chk("mul_start_cnt", 32'(mstart_cnt), 32'd1);
    chk("mul_div_start_cnt", 32'(dstart_cnt), 32'd0);
    chk("mul_start_cycle", 32'(start_c), 32'd1);
    chk("mul_stall_cnt", 32'(stall_cnt), 32'd35);
    chk("mul_wbv_cnt", 32'(wbv_cnt), 32'd1);
    chk("mul_wbv_cycle", 32'(wbv_c), 32'd35);
    chk("mul_data", got_data, 32'd42);
    chk("mul_rd", 32'(got_rd), 32'd5);

    // Fast paths, back to back
    fast_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000);
    fast_op("remu_z", OP_REMU, 32'd5, 32'd0, 5'd9, 32'd5);
    fast_op("divu_z", OP_DIVU, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF);
    req_valid = 1'b0;
    nxt();

    // DIVU 100/7 flushed in 5th WAIT cycle; following MULHU stalls through DRAIN
    clr_stats();
    for (int c = 0; c < 15; c++) begin
      req_valid = (c <= 13);
      if (c <= 6) begin
        alu_op = OP_DIVU; src_a = 32'd100; src_b = 32'd7; rd_in = 5'd3;
      end else begin
        alu_op = OP_MULHU; src_a = 32'hFFFF_FFFF; src_b = 32'd2; rd_in = 5'd11;
      end
      flush = (c == 6);
      div_done = (c == 9); div_result = 32'd14;
      mul_done = (c == 12); mul_result = 32'd1;
      smp();
      record(c);
      if (c == 1) begin
        chk("divu_start", 32'(div_start), 32'd1);
        chk("divu_opc", 32'(div_opcode), 32'd1);
        chk("divu_op1", operand1, 32'd100);
      end
      if (c >= 7 && c <= 10) chk($sformatf("drain_stall_c%0d", c), 32'(stall), 32'd1);
      if (c == 11) begin
        chk("mulhu_start", 32'(mul_start), 32'd1);
        chk("mulhu_op1", operand1, 32'hFFFF_FFFF);
        chk("mulhu_op2", operand2, 32'd2);
        chk("mulhu_opc", 32'(mul_opcode), 32'd3);
      end
      if (c == 13) chk("mulhu_stall_resp", 32'(stall), 32'd0);
      nxt();
    end
    flush = 1'b0; div_done = 1'b0; mul_done = 1'b0;
    chk("flush_dstart_cnt", 32'(dstart_cnt), 32'd1);
    chk("flush_mstart_cnt", 32'(mstart_cnt), 32'd1);
    chk("flush_wbv_cnt", 32'(wbv_cnt), 32'd1);
    chk("flush_wbv_cycle", 32'(wbv_c), 32'd13);
    chk("mulhu_data", got_data, 32'd1);
    chk("mulhu_rd", 32'(got_rd), 32'd11);

    // Watchdog: unit never answers
    clr_stats();
    for (int c = 0; c < 68; c++) begin
      req_valid = (c <= 66); alu_op = OP_MULH; src_a = 32'd3; src_b = 32'd4; rd_in = 5'd1;
      smp();
      record(c);
      if (c == 65) begin
        chk("tmo_before", 32'(timeout_err), 32'd0);
        chk("tmo_stall_last_wait", 32'(stall), 32'd1);
      end
      if (c == 66) chk("tmo_flag", 32'(timeout_err), 32'd1);
      nxt();
    end
    chk("tmo_wbv_cnt", 32'(wbv_cnt), 32'd1);
    chk("tmo_wbv_cycle", 32'(wbv_c), 32'd66);
    chk("tmo_data", got_data, 32'd0);
    chk("tmo_rd", 32'(got_rd), 32'd1);

    // Stray mul_done and ISSUE-cycle div_done while waiting on DIV
    clr_stats();
    for (int c = 0; c < 8; c++) begin
      req_valid = (c <= 6); alu_op = OP_DIV; src_a = 32'hFFFF_FF9C; src_b = 32'd7; rd_in = 5'd4;
      div_done = (c == 1) || (c == 5);
      div_result = (c == 1) ? 32'h0000_0111 : 32'hFFFF_FFF2;
      mul_done = (c == 3); mul_result = 32'h0000_0BAD;
      smp();
      record(c);
      if (c == 6) chk("tmo_sticky", 32'(timeout_err), 32'd1);
      nxt();
    end
    div_done = 1'b0; mul_done = 1'b0;
    chk("stray_wbv_cnt", 32'(wbv_cnt), 32'd1);
    chk("stray_wbv_cycle", 32'(wbv_c), 32'd6);
    chk("stray_data", got_data, 32'hFFFF_FFF2);
    chk("stray_rd", 32'(got_rd), 32'd4);

    // Reset during WAIT of REM
    clr_stats();
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1; alu_op = OP_REM; src_a = 32'd20; src_b = 32'd6; rd_in = 5'd8;
      smp();
      record(c);
      nxt();
    end
    chk("rem_started", 32'(dstart_cnt), 32'd1);
    req_valid = 1'b0; rst = 1'b1;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_wbv", 32'(wb_valid), 32'd0);
    chk("arst_tmo", 32'(timeout_err), 32'd0);
    chk("arst_op1", operand1, 32'd0);
    chk("arst_op2", operand2, 32'd0);
    chk("arst_rd", 32'(wb_rd), 32'd0);
    chk("arst_data", wb_data, 32'd0);
    chk("arst_dopc", 32'(div_opcode), 32'd0);
    nxt();
    div_done = 1'b1; div_result = 32'd2;
    nxt();
    div_done = 1'b0; rst = 1'b0;
    clr_stats();
    for (int c = 0; c < 3; c++) begin
      smp();
      record(c);
      nxt();
    end
    chk("post_rst_wbv", 32'(wbv_cnt), 32'd0);
    chk("post_rst_stall", 32'(stall_cnt), 32'd0);

    // MUL after reset release
    clr_stats();
    for (int c = 0; c < 6; c++) begin
      req_valid = (c <= 4); alu_op = OP_MUL; src_a = 32'd3; src_b = 32'd5; rd_in = 5'd2;
      mul_done = (c == 3); mul_result = 32'd15;
      smp();
      record(c);
      nxt();
    end
    mul_done = 1'b0;
    chk("mul2_start_cycle", 32'(start_c), 32'd1);
    chk("mul2_wbv_cycle", 32'(wbv_c), 32'd4);
    chk("mul2_data", got_data, 32'd15);
    chk("mul2_rd", 32'(got_rd), 32'd2);
    chk("mul2_tmo_clear", 32'(timeout_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
